vu_vxu_banked8_bank_ctrl: RTL and testbench
===========================================

# vu_vxu_banked8_bank_ctrl

Per-bank control stage of the banked-8 vector execution unit, one instance per bank, sitting directly upstream of that bank's register file. It takes the read and write control words marching down the bank chain, derives the local regfile enables, addresses, write-port select and operand-latch enables, and forwards a registered, count-decremented copy to the next bank. It also keeps saturating read/write activity counters for performance monitoring.

## Interface
- BREGLEN_W, 8: regfile address width.
- BOPL_W, 2: operand-latch enable width.
- BWPORT_W, 3: write-port select width.
- CNT_W, 4: remaining-element count width.
- PERF_W, 16: activity counter width.

Ports:
- clk  in  1  clock; one clock; all state on rising edge.
- reset  in  1  synchronous, active-high.
- bank_active  in  1  bank enabled (static during an op).
- in_ren  in  1  read control valid from previous bank.
- in_raddr  in  BREGLEN_W  read address.
- in_rcnt  in  CNT_W  elements still to read.
- in_roplen  in  BOPL_W  operand latches to load with this read.
- in_wen  in  1  write control valid from previous bank.
- in_waddr  in  BREGLEN_W  write address.
- in_wcnt  in  CNT_W  elements still to write.
- in_wsel  in  BWPORT_W  write-port select (0-3 lanes, 4 integer unit).
- out_ren, out_raddr, out_rcnt, out_roplen, out_wen, out_waddr, out_wcnt, out_wsel  out  (as inputs)  registered copy to next bank.
- rf_ren  out  1  regfile read enable.
- rf_raddr  out  BREGLEN_W  regfile read address.
- rf_roplen  out  BOPL_W  regfile operand-latch enable (registered).
- rf_wen  out  1  regfile write enable.
- rf_waddr  out  BREGLEN_W  regfile write address.
- rf_wsel  out  BWPORT_W  regfile write-port select.
- perf_clr  in  1  clear activity counters.
- perf_rd  out  PERF_W  local read fires.
- perf_wr  out  PERF_W  local write fires.

## Operation
- rfire = in_ren & bank_active & (in_rcnt != 0); wfire = in_wen & bank_active & (in_wcnt != 0).
- rf_ren = rfire; rf_raddr = in_raddr; rf_wen = wfire; rf_waddr = in_waddr; rf_wsel = in_wsel when wfire else 0 (combinational).
- Regfile read data is valid the cycle after rf_ren; rf_roplen is therefore a register: rf_roplen <= rfire ? in_roplen : 0.
- Forwarding (registered): out_rcnt <= in_rcnt - rfire; out_ren <= in_ren & (in_rcnt - rfire != 0); out_raddr, out_roplen pass unchanged. Write side identical with wfire/wcnt/waddr/wsel.
- Count never underflows: in_rcnt == 0 gives no fire and out_ren = 0.
- Inactive bank: no local fire, control forwarded with count unchanged.
- Read and write to same address in same cycle: both issued; regfile returns old data; no interlock here.
- perf_rd/perf_wr increment on rfire/wfire, saturate at all-ones; perf_clr zeroes them, takes priority over increment in that cycle.
- Read and write paths independent; both may fire every cycle.

## Timing
- Reset: all out_* = 0, rf_roplen = 0, perf_rd = perf_wr = 0; rf_ren/rf_wen follow inputs combinationally (0 when in_ren/in_wen = 0).
- Local enable latency 0 cycles; operand-latch enable 1 cycle after rf_ren; bank-to-bank latency 1 cycle.
- Reset asserted mid-op: next edge clears forwarded controls and rf_roplen; in-flight elements downstream are dropped, not resumed.

## Test plan
- Active bank, in_ren=1, in_raddr=0x12, in_rcnt=3, in_roplen=2'b01 -> same cycle rf_ren=1, rf_raddr=0x12; next cycle rf_roplen=01, out_ren=1, out_rcnt=2, out_raddr=0x12.
- in_rcnt=1 active -> rf_ren=1; next cycle out_ren=0, out_rcnt=0. in_rcnt=0, in_ren=1 -> rf_ren=0, out_ren=0.
- bank_active=0, in_wen=1, in_wcnt=5, in_wsel=4 -> rf_wen=0, rf_wsel=0; next cycle out_wen=1, out_wcnt=5, out_wsel=4.
- Simultaneous read/write, raddr=waddr=0x07, both counts 2 -> rf_ren=rf_wen=1 same cycle; next cycle out_rcnt=out_wcnt=1.
- Fire reads continuously with PERF_W=4 for 20 cycles -> perf_rd stops at 15; assert perf_clr with rfire=1 -> perf_rd=0 next cycle.
- Reset asserted while out_ren=1, rf_roplen=11 -> next cycle all out_* and rf_roplen are 0, counters 0.

Source files
------------

// File: rtl/vu_vxu_banked8_bank_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : vu_vxu_banked8_bank_ctrl
// Description : Per-bank control stage of the banked-8 vector execution unit.
//               Derives local regfile read/write enables, addresses, write-port
//               select and operand-latch enables from the control words moving
//               down the bank chain. Forwards a registered, count-decremented
//               copy to the next bank. Keeps saturating read/write activity
//               counters.
// Ports       : clk, reset            - clock, synchronous active-high reset
//               bank_active           - bank enabled for the current op
//               in_r*/in_w*           - read/write control from previous bank
//               out_r*/out_w*         - registered control to next bank
//               rf_*                  - local regfile controls (rf_roplen is
//                                       registered, the rest combinational)
//               perf_clr              - clear activity counters
//               perf_rd/perf_wr       - saturating local fire counters
// Revision    : 1.0 - initial release
// ============================================================================
module vu_vxu_banked8_bank_ctrl #(
   parameter int BREGLEN_W = 8,
   parameter int BOPL_W    = 2,
   parameter int BWPORT_W  = 3,
   parameter int CNT_W     = 4,
   parameter int PERF_W    = 16
) (
   input  logic                 clk,
   input  logic                 reset,
   input  logic                 bank_active,
   input  logic                 in_ren,
   input  logic [BREGLEN_W-1:0] in_raddr,
   input  logic [CNT_W-1:0]     in_rcnt,
   input  logic [BOPL_W-1:0]    in_roplen,
   input  logic                 in_wen,
   input  logic [BREGLEN_W-1:0] in_waddr,
   input  logic [CNT_W-1:0]     in_wcnt,
   input  logic [BWPORT_W-1:0]  in_wsel,
   output logic                 out_ren,
   output logic [BREGLEN_W-1:0] out_raddr,
   output logic [CNT_W-1:0]     out_rcnt,
   output logic [BOPL_W-1:0]    out_roplen,
   output logic                 out_wen,
   output logic [BREGLEN_W-1:0] out_waddr,
   output logic [CNT_W-1:0]     out_wcnt,
   output logic [BWPORT_W-1:0]  out_wsel,
   output logic                 rf_ren,
   output logic [BREGLEN_W-1:0] rf_raddr,
   output logic [BOPL_W-1:0]    rf_roplen,
   output logic                 rf_wen,
   output logic [BREGLEN_W-1:0] rf_waddr,
   output logic [BWPORT_W-1:0]  rf_wsel,
   input  logic                 perf_clr,
   output logic [PERF_W-1:0]    perf_rd,
   output logic [PERF_W-1:0]    perf_wr
);

   localparam logic [PERF_W-1:0] c_perf_max = {PERF_W{1'b1}};

   logic             w_rfire;
   logic             w_wfire;
   logic [CNT_W-1:0] w_rcnt_nxt;
   logic [CNT_W-1:0] w_wcnt_nxt;

   logic                 r_out_ren;
   logic [BREGLEN_W-1:0] r_out_raddr;
   logic [CNT_W-1:0]     r_out_rcnt;
   logic [BOPL_W-1:0]    r_out_roplen;
   logic                 r_out_wen;
   logic [BREGLEN_W-1:0] r_out_waddr;
   logic [CNT_W-1:0]     r_out_wcnt;
   logic [BWPORT_W-1:0]  r_out_wsel;
   logic [BOPL_W-1:0]    r_rf_roplen;
   logic [PERF_W-1:0]    r_perf_rd;
   logic [PERF_W-1:0]    r_perf_wr;

   // A zero count never fires, so the decrement below cannot underflow.
   assign w_rfire    = in_ren & bank_active & (in_rcnt != '0);
   assign w_wfire    = in_wen & bank_active & (in_wcnt != '0);
   assign w_rcnt_nxt = in_rcnt - CNT_W'(w_rfire);
   assign w_wcnt_nxt = in_wcnt - CNT_W'(w_wfire);

   // Local regfile controls are combinational: zero-cycle enable latency.
   assign rf_ren   = w_rfire;
   assign rf_raddr = in_raddr;
   assign rf_wen   = w_wfire;
   assign rf_waddr = in_waddr;
   assign rf_wsel  = w_wfire ? in_wsel : '0;

   always_ff @(posedge clk) begin
      if (reset) begin
         r_out_ren    <= 1'b0;
         r_out_raddr  <= '0;
         r_out_rcnt   <= '0;
         r_out_roplen <= '0;
         r_out_wen    <= 1'b0;
         r_out_waddr  <= '0;
         r_out_wcnt   <= '0;
         r_out_wsel   <= '0;
         r_rf_roplen  <= '0;
      end else begin
         // Control marches on whether or not this bank consumed an element.
         r_out_ren    <= in_ren & (w_rcnt_nxt != '0);
         r_out_raddr  <= in_raddr;
         r_out_rcnt   <= w_rcnt_nxt;
         r_out_roplen <= in_roplen;
         r_out_wen    <= in_wen & (w_wcnt_nxt != '0);
         r_out_waddr  <= in_waddr;
         r_out_wcnt   <= w_wcnt_nxt;
         r_out_wsel   <= in_wsel;
         // Read data appears one cycle after rf_ren, so latch enables lag too.
         r_rf_roplen  <= w_rfire ? in_roplen : '0;
      end
   end

   always_ff @(posedge clk) begin
      if (reset || perf_clr) begin
         r_perf_rd <= '0;
         r_perf_wr <= '0;
      end else begin
         if (w_rfire && (r_perf_rd != c_perf_max)) begin
            r_perf_rd <= r_perf_rd + 1'b1;
         end
         if (w_wfire && (r_perf_wr != c_perf_max)) begin
            r_perf_wr <= r_perf_wr + 1'b1;
         end
      end
   end

   assign out_ren    = r_out_ren;
   assign out_raddr  = r_out_raddr;
   assign out_rcnt   = r_out_rcnt;
   assign out_roplen = r_out_roplen;
   assign out_wen    = r_out_wen;
   assign out_waddr  = r_out_waddr;
   assign out_wcnt   = r_out_wcnt;
   assign out_wsel   = r_out_wsel;
   assign rf_roplen  = r_rf_roplen;
   assign perf_rd    = r_perf_rd;
   assign perf_wr    = r_perf_wr;

endmodule
`default_nettype wire

// File: tb/tb_vu_vxu_banked8_bank_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : tb_vu_vxu_banked8_bank_ctrl
// Description : Self-checking bench for vu_vxu_banked8_bank_ctrl. Directed
//               scenarios with literal expectations, then randomized traffic
//               checked every cycle against a behavioural model.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_vu_vxu_banked8_bank_ctrl;

   localparam int BREGLEN_W = 8;
   localparam int BOPL_W    = 2;
   localparam int BWPORT_W  = 3;
   localparam int CNT_W     = 4;
   localparam int PERF_W    = 4;
   localparam int PERF_MAX  = (1 << PERF_W) - 1;

   logic                 clk = 1'b0;
   logic                 reset;
   logic                 bank_active;
   logic                 in_ren;
   logic [BREGLEN_W-1:0] in_raddr;
   logic [CNT_W-1:0]     in_rcnt;
   logic [BOPL_W-1:0]    in_roplen;
   logic                 in_wen;
   logic [BREGLEN_W-1:0] in_waddr;
   logic [CNT_W-1:0]     in_wcnt;
   logic [BWPORT_W-1:0]  in_wsel;
   logic                 out_ren;
   logic [BREGLEN_W-1:0] out_raddr;
   logic [CNT_W-1:0]     out_rcnt;
   logic [BOPL_W-1:0]    out_roplen;
   logic                 out_wen;
   logic [BREGLEN_W-1:0] out_waddr;
   logic [CNT_W-1:0]     out_wcnt;
   logic [BWPORT_W-1:0]  out_wsel;
   logic                 rf_ren;
   logic [BREGLEN_W-1:0] rf_raddr;
   logic [BOPL_W-1:0]    rf_roplen;
   logic                 rf_wen;
   logic [BREGLEN_W-1:0] rf_waddr;
   logic [BWPORT_W-1:0]  rf_wsel;
   logic                 perf_clr;
   logic [PERF_W-1:0]    perf_rd;
   logic [PERF_W-1:0]    perf_wr;

   int n_tests = 0;
   int n_fail  = 0;

   always #5 clk = ~clk;

   vu_vxu_banked8_bank_ctrl #(
      .BREGLEN_W (BREGLEN_W),
      .BOPL_W    (BOPL_W),
      .BWPORT_W  (BWPORT_W),
      .CNT_W     (CNT_W),
      .PERF_W    (PERF_W)
   ) dut (
      .clk         (clk),
      .reset       (reset),
      .bank_active (bank_active),
      .in_ren      (in_ren),
      .in_raddr    (in_raddr),
      .in_rcnt     (in_rcnt),
      .in_roplen   (in_roplen),
      .in_wen      (in_wen),
      .in_waddr    (in_waddr),
      .in_wcnt     (in_wcnt),
      .in_wsel     (in_wsel),
      .out_ren     (out_ren),
      .out_raddr   (out_raddr),
      .out_rcnt    (out_rcnt),
      .out_roplen  (out_roplen),
      .out_wen     (out_wen),
      .out_waddr   (out_waddr),
      .out_wcnt    (out_wcnt),
      .out_wsel    (out_wsel),
      .rf_ren      (rf_ren),
      .rf_raddr    (rf_raddr),
      .rf_roplen   (rf_roplen),
      .rf_wen      (rf_wen),
      .rf_waddr    (rf_waddr),
      .rf_wsel     (rf_wsel),
      .perf_clr    (perf_clr),
      .perf_rd     (perf_rd),
      .perf_wr     (perf_wr)
   );

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_tests++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, exp, $time);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   // ------------------------------------------------------------------
   // Behavioural model: what every registered output must hold, given
   // the inputs seen at the last rising edge.
   // ------------------------------------------------------------------
   bit   mdl_valid = 1'b0;
   int   m_ren, m_raddr, m_rcnt, m_roplen;
   int   m_wen, m_waddr, m_wcnt, m_wsel;
   int   m_rf_roplen, m_perf_rd, m_perf_wr;
   int   m_rfire, m_wfire;

   always @(posedge clk) begin
      if (reset) begin
         m_ren = 0; m_raddr = 0; m_rcnt = 0; m_roplen = 0;
         m_wen = 0; m_waddr = 0; m_wcnt = 0; m_wsel = 0;
         m_rf_roplen = 0; m_perf_rd = 0; m_perf_wr = 0;
         mdl_valid = 1'b1;
      end else if (mdl_valid) begin
         m_rfire = (in_ren && bank_active && int'(in_rcnt) > 0) ? 1 : 0;
         m_wfire = (in_wen && bank_active && int'(in_wcnt) > 0) ? 1 : 0;
         m_rcnt   = int'(in_rcnt) - m_rfire;
         m_wcnt   = int'(in_wcnt) - m_wfire;
         m_ren    = (in_ren && m_rcnt > 0) ? 1 : 0;
         m_wen    = (in_wen && m_wcnt > 0) ? 1 : 0;
         m_raddr  = int'(in_raddr);
         m_waddr  = int'(in_waddr);
         m_roplen = int'(in_roplen);
         m_wsel   = int'(in_wsel);
         m_rf_roplen = m_rfire ? int'(in_roplen) : 0;
         if (perf_clr) begin
            m_perf_rd = 0;
            m_perf_wr = 0;
         end else begin
            if (m_rfire && m_perf_rd < PERF_MAX) m_perf_rd++;
            if (m_wfire && m_perf_wr < PERF_MAX) m_perf_wr++;
         end
      end
   end

   // Compare process: checks every output mid-cycle.
   always @(negedge clk) begin
      if (mdl_valid) begin
         chk("rf_ren",   {31'd0, rf_ren},
             {31'd0, in_ren & bank_active & (int'(in_rcnt) > 0)});
         chk("rf_wen",   {31'd0, rf_wen},
             {31'd0, in_wen & bank_active & (int'(in_wcnt) > 0)});
         chk("rf_raddr", 32'(rf_raddr), 32'(in_raddr));
         chk("rf_waddr", 32'(rf_waddr), 32'(in_waddr));
         chk("rf_wsel",  32'(rf_wsel),
             (in_wen && bank_active && int'(in_wcnt) > 0) ? 32'(in_wsel) : 32'd0);
         chk("out_ren",    32'(out_ren),    m_ren);
         chk("out_raddr",  32'(out_raddr),  m_raddr);
         chk("out_rcnt",   32'(out_rcnt),   m_rcnt);
         chk("out_roplen", 32'(out_roplen), m_roplen);
         chk("out_wen",    32'(out_wen),    m_wen);
         chk("out_waddr",  32'(out_waddr),  m_waddr);
         chk("out_wcnt",   32'(out_wcnt),   m_wcnt);
         chk("out_wsel",   32'(out_wsel),   m_wsel);
         chk("rf_roplen",  32'(rf_roplen),  m_rf_roplen);
         chk("perf_rd",    32'(perf_rd),    m_perf_rd);
         chk("perf_wr",    32'(perf_wr),    m_perf_wr);
      end
   end

   task automatic idle_inputs();
      bank_active = 1'b1;
      in_ren = 1'b0; in_raddr = '0; in_rcnt = '0; in_roplen = '0;
      in_wen = 1'b0; in_waddr = '0; in_wcnt = '0; in_wsel = '0;
      perf_clr = 1'b0;
   endtask

   initial begin
      reset = 1'b1;
      idle_inputs();
      repeat (2) tick();
      reset = 1'b0;
      chk("rst_out_ren",   32'(out_ren), 0);
      chk("rst_rf_roplen", 32'(rf_roplen), 0);
      chk("rst_perf_rd",   32'(perf_rd), 0);

      // Single read, count 3
      in_ren = 1'b1; in_raddr = 8'h12; in_rcnt = 4'd3; in_roplen = 2'b01;
      @(negedge clk);
      chk("t1_rf_ren",   32'(rf_ren), 1);
      chk("t1_rf_raddr", 32'(rf_raddr), 32'h12);
      tick();
      chk("t1_rf_roplen", 32'(rf_roplen), 1);
      chk("t1_out_ren",   32'(out_ren), 1);
      chk("t1_out_rcnt",  32'(out_rcnt), 2);
      chk("t1_out_raddr", 32'(out_raddr), 32'h12);

      // Last element, then zero count
      in_rcnt = 4'd1;
      @(negedge clk);
      chk("t2_rf_ren", 32'(rf_ren), 1);
      tick();
      chk("t2_out_ren",  32'(out_ren), 0);
      chk("t2_out_rcnt", 32'(out_rcnt), 0);
      in_rcnt = 4'd0;
      @(negedge clk);
      chk("t2z_rf_ren", 32'(rf_ren), 0);
      tick();
      chk("t2z_out_ren", 32'(out_ren), 0);

      // Inactive bank passes writes through untouched
      idle_inputs();
      bank_active = 1'b0; in_wen = 1'b1; in_wcnt = 4'd5; in_wsel = 3'd4;
      @(negedge clk);
      chk("t3_rf_wen",  32'(rf_wen), 0);
      chk("t3_rf_wsel", 32'(rf_wsel), 0);
      tick();
      chk("t3_out_wen",  32'(out_wen), 1);
      chk("t3_out_wcnt", 32'(out_wcnt), 5);
      chk("t3_out_wsel", 32'(out_wsel), 4);

      // Simultaneous read and write, same address
      idle_inputs();
      in_ren = 1'b1; in_raddr = 8'h07; in_rcnt = 4'd2;
      in_wen = 1'b1; in_waddr = 8'h07; in_wcnt = 4'd2;
      @(negedge clk);
      chk("t4_rf_ren", 32'(rf_ren), 1);
      chk("t4_rf_wen", 32'(rf_wen), 1);
      tick();
      chk("t4_out_rcnt", 32'(out_rcnt), 1);
      chk("t4_out_wcnt", 32'(out_wcnt), 1);

      // Saturation of the read counter, then clear with a fire pending
      idle_inputs();
      perf_clr = 1'b1; in_ren = 1'b1; in_rcnt = 4'd3;
      tick();
      perf_clr = 1'b0;
      chk("t5_perf_cleared", 32'(perf_rd), 0);
      repeat (20) tick();
      chk("t5_perf_sat", 32'(perf_rd), 15);
      perf_clr = 1'b1;
      tick();
      chk("t5_perf_clr", 32'(perf_rd), 0);
      perf_clr = 1'b0;

      // Reset mid-op
      in_ren = 1'b1; in_rcnt = 4'd3; in_roplen = 2'b11;
      in_wen = 1'b1; in_wcnt = 4'd4;
      tick();
      chk("t6_out_ren",   32'(out_ren), 1);
      chk("t6_rf_roplen", 32'(rf_roplen), 3);
      reset = 1'b1;
      tick();
      reset = 1'b0;
      chk("t6_rst_out_ren",   32'(out_ren), 0);
      chk("t6_rst_out_rcnt",  32'(out_rcnt), 0);
      chk("t6_rst_out_roplen",32'(out_roplen), 0);
      chk("t6_rst_out_wen",   32'(out_wen), 0);
      chk("t6_rst_out_wcnt",  32'(out_wcnt), 0);
      chk("t6_rst_rf_roplen", 32'(rf_roplen), 0);
      chk("t6_rst_perf_rd",   32'(perf_rd), 0);
      chk("t6_rst_perf_wr",   32'(perf_wr), 0);

      // Randomized traffic
      for (int i = 0; i < 500; i++) begin
         bank_active = ($urandom_range(0, 4) != 0);
         in_ren    = $urandom_range(0, 1) == 1;
         in_raddr  = BREGLEN_W'($urandom);
         in_rcnt   = ($urandom_range(0, 3) == 0) ? CNT_W'($urandom) : CNT_W'($urandom_range(0, 2));
         in_roplen = BOPL_W'($urandom);
         in_wen    = $urandom_range(0, 1) == 1;
         in_waddr  = BREGLEN_W'($urandom);
         in_wcnt   = ($urandom_range(0, 3) == 0) ? CNT_W'($urandom) : CNT_W'($urandom_range(0, 2));
         in_wsel   = BWPORT_W'($urandom_range(0, 4));
         perf_clr  = ($urandom_range(0, 40) == 0);
         reset     = ($urandom_range(0, 60) == 0);
         tick();
      end
      reset = 1'b0;
      idle_inputs();
      tick();

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
`default_nettype wire
